sap_sequencer: RTL and testbench
================================

# sap_sequencer

Six-state ring-counter sequencer and microinstruction decoder for the SAP-1 datapath. It sits directly upstream of the SAP top level. It takes the opcode nibble from the instruction register and drives the 12-bit control word that gates the program counter, memory address register, RAM, accumulator, B register, ALU and output register. Fetch takes T1–T3. Execute takes T4–T6. A HLT opcode freezes the machine until reset.

## Interface
- Parameters: none. All widths are fixed by the SAP-1 control word format.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `instruction`  in  4  opcode, instruction register bits [7:4]; valid from T4 through T6.
- `control_word`  out  12  bit order {Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo}; Cp, Ep, Ea, Su, Eu active-high; Lm, Ce, Li, Ei, La, Lb, Lo active-low.
- `t_state`  out  6  one-hot ring position; bit 0 = T1 … bit 5 = T6; all zero when halted.
- `halt`  out  1  high while in the HALT state.

## Operation
- State: a one-hot ring T1→T2→T3→T4→T5→T6→T1, plus a terminal HALT state.
- The idle control word is 12'h3E3: every enable inactive, every active-low load high.
- `control_word` is combinational from the current state and `instruction`. It has no registered delay.
- Fetch control words, independent of opcode:
  - T1 = 12'h5E3 (Ep, Lm).
  - T2 = 12'hBE3 (Cp).
  - T3 = 12'h263 (Ce, Li).
- LDA 4'b0000: T4 = 12'h1A3 (Ei, Lm); T5 = 12'h2C3 (Ce, La); T6 = 12'h3E3.
- ADD 4'b0001: T4 = 12'h1A3; T5 = 12'h2E1 (Ce, Lb); T6 = 12'h3C7 (Eu, La).
- SUB 4'b0010: T4 = 12'h1A3; T5 = 12'h2E1; T6 = 12'h3CF (Su, Eu, La).
- OUT 4'b1110: T4 = 12'h3F2 (Ea, Lo); T5 = T6 = 12'h3E3.
- HLT 4'b1111:
  - T4 outputs 12'h3E3.
  - The next state is HALT instead of T5.
  - HALT is held indefinitely: `t_state` = 6'b0, `control_word` = 12'h3E3, `halt` = 1.
- Opcodes 4'b0011–4'b1101 are NOPs. T4–T6 output 12'h3E3 and the ring continues.
- `instruction` is ignored in T1–T3. Changes during fetch have no effect.
- Fetch control words never assert two bus drivers (Ep, Ce, Ei, Ea, Eu) at once. Execute control words must not either.

## Timing
- Reset:
  - When `reset` is high at a rising edge, the state becomes T1 regardless of the current state, including HALT and mid-execute.
  - While `reset` is high, `control_word` is forced to 12'h3E3. No load or increment occurs during reset.
  - After reset: `t_state` = 6'b000001, `halt` = 0.
- The first rising edge with `reset` low executes T1 (address load) and advances the ring to T2.
- One T-state per clock. Every instruction takes exactly 6 cycles. The opcode loaded on the T3 edge is decoded from T4.
- `halt` rises in the cycle after the HLT T4 cycle. That is the 5th cycle of the HLT instruction.
- Wrap-around: T6 → T1 every instruction. No idle cycle is inserted.

## Test plan
- Reset check:
  - Stimulus: hold `reset` for 2 cycles, then release.
  - Required: `control_word` = 3E3 during reset. Then 5E3, BE3, 263 on consecutive cycles with `t_state` 000001, 000010, 000100.
- LDA/ADD/SUB sequences:
  - Stimulus: run each opcode (0000, 0001, 0010) through T4–T6.
  - Required: LDA gives 1A3, 2C3, 3E3. ADD gives 1A3, 2E1, 3C7. SUB gives 1A3, 2E1, 3CF. T1 follows T6.
- OUT and NOP:
  - Stimulus: `instruction` = 1110, then 0101.
  - Required: OUT gives 3F2, 3E3, 3E3. The NOP gives 3E3 ×3. The ring keeps cycling.
- HLT:
  - Stimulus: `instruction` = 1111 at T4, then hold for 20 cycles.
  - Required: `halt` = 1, `t_state` = 0 and `control_word` = 3E3 throughout. Asserting `reset` returns the block to T1 with `halt` = 0.
- Mid-instruction reset:
  - Stimulus: assert `reset` during ADD T5.
  - Required: the next cycle is T1 with 12'h5E3 once `reset` drops. No 2E1 or 3C7 appears after the reset edge.
- Opcode glitch:
  - Stimulus: toggle `instruction` randomly during T1–T3.
  - Required: the fetch control words are unchanged.

Source files
------------

// File: rtl/sap_sequencer.sv
// sap_sequencer: six-state ring-counter sequencer and microinstruction
// decoder for the SAP-1 datapath. Fetch runs T1-T3, execute runs T4-T6;
// a HLT opcode parks the machine in HALT until reset.
module sap_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  instruction,
  output logic [11:0] control_word,
  output logic [5:0]  t_state,
  output logic        halt
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    ST_T1   = 3'd0,
    ST_T2   = 3'd1,
    ST_T3   = 3'd2,
    ST_T4   = 3'd3,
    ST_T5   = 3'd4,
    ST_T6   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  // Microinstruction fields, each high when that action is wanted; polarity
  // of the active-low loads is applied only when the word is assembled.
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

  // State register: reset always returns to T1, even from HALT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_T1;
    end else begin
      state <= state_next;
    end
  end

  // Next state: plain ring, except HLT at T4 diverts into the HALT sink.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_T1:   state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3:   state_next = ST_T4;
      ST_T4:   state_next = (instruction == OP_HLT) ? ST_HALT : ST_T5;
      ST_T5:   state_next = ST_T6;
      ST_T6:   state_next = ST_T1;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_T1;
    endcase
  end

  // Decode: fetch ignores the opcode; execute steps depend on it. Reset
  // suppresses every action so nothing loads or increments during reset.
  always_comb begin
    cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0;
    li = 1'b0; ei = 1'b0; la = 1'b0; ea = 1'b0;
    su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;
    if (!reset) begin
      case (state)
        ST_T1: begin ep = 1'b1; lm = 1'b1; end
        ST_T2: begin cp = 1'b1; end
        ST_T3: begin ce = 1'b1; li = 1'b1; end
        ST_T4: begin
          if (instruction == OP_LDA || instruction == OP_ADD ||
              instruction == OP_SUB) begin
            ei = 1'b1; lm = 1'b1;
          end else if (instruction == OP_OUT) begin
            ea = 1'b1; lo = 1'b1;
          end
        end
        ST_T5: begin
          if (instruction == OP_LDA) begin
            ce = 1'b1; la = 1'b1;
          end else if (instruction == OP_ADD || instruction == OP_SUB) begin
            ce = 1'b1; lb = 1'b1;
          end
        end
        ST_T6: begin
          if (instruction == OP_ADD) begin
            eu = 1'b1; la = 1'b1;
          end else if (instruction == OP_SUB) begin
            su = 1'b1; eu = 1'b1; la = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output assembly: active-low loads are inverted into the word.
  always_comb begin
    control_word = {cp, ep, ~lm, ~ce, ~li, ~ei, ~la, ea, su, eu, ~lb, ~lo};
    halt         = (state == ST_HALT);
    case (state)
      ST_T1:   t_state = 6'b000001;
      ST_T2:   t_state = 6'b000010;
      ST_T3:   t_state = 6'b000100;
      ST_T4:   t_state = 6'b001000;
      ST_T5:   t_state = 6'b010000;
      ST_T6:   t_state = 6'b100000;
      default: t_state = 6'b000000;
    endcase
  end

endmodule

// File: tb/tb_sap_sequencer.sv
// Testbench for sap_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic against a phase/halt reference model.
module tb_sap_sequencer;

  logic        clock;
  logic        reset;
  logic [3:0]  instruction;
  logic [11:0] control_word;
  logic [5:0]  t_state;
  logic        halt;

  int n_checks;
  int n_fail;

  // Reference model: instruction phase 0..5 (T1..T6) plus a halted flag.
  int m_phase;
  bit m_halted;
  bit m_known;

  typedef struct {
    bit          rst;
    logic [3:0]  ins;
    logic [11:0] cw;
    logic [5:0]  ts;
    bit          hl;
  } vec_t;

  vec_t vecs[$];

  sap_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .control_word (control_word),
    .t_state      (t_state),
    .halt         (halt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exec_word(input logic [3:0] op, input int k);
    logic [11:0] w;
    w = 12'h3E3;
    case (op)
      4'h0: w = (k == 0) ? 12'h1A3 : (k == 1) ? 12'h2C3 : 12'h3E3;
      4'h1: w = (k == 0) ? 12'h1A3 : (k == 1) ? 12'h2E1 : 12'h3C7;
      4'h2: w = (k == 0) ? 12'h1A3 : (k == 1) ? 12'h2E1 : 12'h3CF;
      4'hE: w = (k == 0) ? 12'h3F2 : 12'h3E3;
      default: w = 12'h3E3;
    endcase
    return w;
  endfunction

  function automatic logic [11:0] model_cw(input bit rst, input logic [3:0] ins);
    if (rst || m_halted) return 12'h3E3;
    if (m_phase == 0) return 12'h5E3;
    if (m_phase == 1) return 12'hBE3;
    if (m_phase == 2) return 12'h263;
    return exec_word(ins, m_phase - 3);
  endfunction

  function automatic logic [5:0] model_ts();
    logic [5:0] one;
    one = 6'b000001;
    if (m_halted) return 6'b000000;
    return one << m_phase;
  endfunction

  task automatic model_step(input bit rst, input logic [3:0] ins);
    if (rst) begin
      m_phase  = 0;
      m_halted = 1'b0;
      m_known  = 1'b1;
    end else if (m_known && !m_halted) begin
      if (m_phase == 3 && ins == 4'hF) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 6;
    end
  endtask

  // One clock: drive on the low phase, check just after, then take the edge.
  task automatic cycle(input bit rst, input logic [3:0] ins, input string tag);
    reset       = rst;
    instruction = ins;
    #1;
    if (m_known) begin
      check({tag, ".cw"},   control_word,          model_cw(rst, ins));
      check({tag, ".ts"},   {6'b0, t_state},       {6'b0, model_ts()});
      check({tag, ".halt"}, {11'b0, halt},         {11'b0, m_halted});
    end
    @(posedge clock);
    model_step(rst, ins);
    @(negedge clock);
  endtask

  task automatic add(input bit r, input logic [3:0] i, input logic [11:0] c,
                     input logic [5:0] t, input bit h);
    vec_t v;
    v.rst = r; v.ins = i; v.cw = c; v.ts = t; v.hl = h;
    vecs.push_back(v);
  endtask

  // Run forward until the model reaches the given phase, bounded.
  task automatic run_to(input int ph, input logic [3:0] ins, input string tag);
    for (int i = 0; i < 12 && (m_phase != ph || m_halted); i++) cycle(1'b0, ins, tag);
    check({tag, ".reach"}, m_phase[11:0], ph[11:0]);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_phase = 0; m_halted = 1'b0; m_known = 1'b0;
    reset = 1'b1; instruction = 4'h0;

    // Directed vector table, expected words written out by hand.
    add(1, 4'h0, 12'h3E3, 6'b000001, 0);
    add(0, 4'h7, 12'h5E3, 6'b000001, 0);
    add(0, 4'hF, 12'hBE3, 6'b000010, 0);
    add(0, 4'h3, 12'h263, 6'b000100, 0);
    add(0, 4'h0, 12'h1A3, 6'b001000, 0);
    add(0, 4'h0, 12'h2C3, 6'b010000, 0);
    add(0, 4'h0, 12'h3E3, 6'b100000, 0);
    add(0, 4'h0, 12'h5E3, 6'b000001, 0);
    add(0, 4'h1, 12'hBE3, 6'b000010, 0);
    add(0, 4'h1, 12'h263, 6'b000100, 0);
    add(0, 4'h1, 12'h1A3, 6'b001000, 0);
    add(0, 4'h1, 12'h2E1, 6'b010000, 0);
    add(0, 4'h1, 12'h3C7, 6'b100000, 0);
    add(0, 4'h2, 12'h5E3, 6'b000001, 0);
    add(0, 4'hE, 12'hBE3, 6'b000010, 0);
    add(0, 4'h2, 12'h263, 6'b000100, 0);
    add(0, 4'h2, 12'h1A3, 6'b001000, 0);
    add(0, 4'h2, 12'h2E1, 6'b010000, 0);
    add(0, 4'h2, 12'h3CF, 6'b100000, 0);
    add(0, 4'hE, 12'h5E3, 6'b000001, 0);
    add(0, 4'hE, 12'hBE3, 6'b000010, 0);
    add(0, 4'hE, 12'h263, 6'b000100, 0);
    add(0, 4'hE, 12'h3F2, 6'b001000, 0);
    add(0, 4'hE, 12'h3E3, 6'b010000, 0);
    add(0, 4'hE, 12'h3E3, 6'b100000, 0);
    add(0, 4'h5, 12'h5E3, 6'b000001, 0);
    add(0, 4'h5, 12'hBE3, 6'b000010, 0);
    add(0, 4'h5, 12'h263, 6'b000100, 0);
    add(0, 4'h5, 12'h3E3, 6'b001000, 0);
    add(0, 4'h5, 12'h3E3, 6'b010000, 0);
    add(0, 4'h5, 12'h3E3, 6'b100000, 0);
    add(0, 4'hF, 12'h5E3, 6'b000001, 0);
    add(0, 4'hF, 12'hBE3, 6'b000010, 0);
    add(0, 4'hF, 12'h263, 6'b000100, 0);
    add(0, 4'hF, 12'h3E3, 6'b001000, 0);
    add(0, 4'hF, 12'h3E3, 6'b000000, 1);
    add(0, 4'h0, 12'h3E3, 6'b000000, 1);
    add(0, 4'h1, 12'h3E3, 6'b000000, 1);
    add(1, 4'hF, 12'h3E3, 6'b000000, 1);
    add(0, 4'hF, 12'h5E3, 6'b000001, 0);

    // First reset edge brings the DUT to a known T1.
    @(negedge clock);
    cycle(1'b1, 4'h0, "init");

    foreach (vecs[i]) begin
      reset       = vecs[i].rst;
      instruction = vecs[i].ins;
      #1;
      check($sformatf("vec%0d.cw", i),   control_word,    vecs[i].cw);
      check($sformatf("vec%0d.ts", i),   {6'b0, t_state}, {6'b0, vecs[i].ts});
      check($sformatf("vec%0d.halt", i), {11'b0, halt},   {11'b0, vecs[i].hl});
      @(posedge clock);
      model_step(vecs[i].rst, vecs[i].ins);
      @(negedge clock);
    end

    // Reset during ADD T5: no 2E1/3C7 may follow.
    run_to(4, 4'h1, "midrst");
    cycle(1'b1, 4'h1, "midrst.r");
    cycle(1'b0, 4'h1, "midrst.t1");
    cycle(1'b0, 4'h1, "midrst.t2");
    check("midrst.no2E1", {11'b0, (control_word == 12'h2E1)}, 12'h000);

    // Opcode glitching through fetch leaves fetch words untouched.
    run_to(0, 4'h0, "glitch");
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'($urandom_range(0, 15)), "glitch.f");
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h2, "glitch.x");

    // HLT then 20 halted cycles with random opcodes, then reset recovery.
    run_to(3, 4'hF, "hlt");
    cycle(1'b0, 4'hF, "hlt.t4");
    for (int i = 0; i < 20; i++) cycle(1'b0, 4'($urandom_range(0, 15)), "hlt.hold");
    cycle(1'b1, 4'hF, "hlt.rst");
    cycle(1'b0, 4'hF, "hlt.t1");

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
